// File: rtl/mips_instr_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder / program loader:
// symbolic op codes, real opcode/funct fields and small word-building helpers.
package mips_instr_encoder_pkg;

  // Symbolic request ops; values above OP_LAST are undefined and rejected.
  typedef enum logic [5:0] {
    OP_NOP     = 6'd0,
    OP_ADD     = 6'd1,
    OP_SUB     = 6'd2,
    OP_AND     = 6'd3,
    OP_OR      = 6'd4,
    OP_SLT     = 6'd5,
    OP_SLTU    = 6'd6,
    OP_JR      = 6'd7,
    OP_MULT    = 6'd8,
    OP_MULTU   = 6'd9,
    OP_DIV     = 6'd10,
    OP_DIVU    = 6'd11,
    OP_MFHI    = 6'd12,
    OP_MFLO    = 6'd13,
    OP_MTHI    = 6'd14,
    OP_MTLO    = 6'd15,
    OP_ADDI    = 6'd16,
    OP_ANDI    = 6'd17,
    OP_ORI     = 6'd18,
    OP_LUI     = 6'd19,
    OP_LW      = 6'd20,
    OP_LH      = 6'd21,
    OP_LB      = 6'd22,
    OP_SW      = 6'd23,
    OP_SH      = 6'd24,
    OP_SB      = 6'd25,
    OP_BEQ     = 6'd26,
    OP_BNE     = 6'd27,
    OP_JAL     = 6'd28,
    OP_MFC0    = 6'd29,
    OP_MTC0    = 6'd30,
    OP_ERET    = 6'd31,
    OP_SYSCALL = 6'd32
  } op_e;

  localparam logic [5:0] OP_LAST = 6'd32;

  // Encoded-word buffer depth; must be a power of two and at least 2.
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_COP0    = 6'h10;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LH      = 6'h21;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // COP0 rs-field selectors and the fixed eret word
  localparam logic [4:0]  COP0_MF   = 5'd0;
  localparam logic [4:0]  COP0_MT   = 5'd4;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // R-type word with shamt held at zero.
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_SPECIAL, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type word; the immediate is used exactly as given.
  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_instr_fifo.sv
// Small synchronous FIFO holding encoded words between the encoder and IM.
// Head data reads as zero while empty so the IM data bus is quiet when idle.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Self-test program loader: encodes symbolic instruction requests into MIPS
// words, queues them and writes them to instruction memory at consecutive
// word addresses starting from RESET_ADDR or a loaded base.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [15:0]      req_imm,
  input  logic [25:0]      req_target,
  input  logic             base_load,
  input  logic [31:0]      base_addr,
  output logic             im_we,
  input  logic             im_ready,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic [CNT_W-1:0] word_cnt,
  output logic             err_illegal
);

  // Symbolic op plus fields to a 32-bit word; fields an op does not use are zeroed.
  function automatic logic [31:0] encode_instr(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [15:0] imm, input logic [25:0] target);
    logic [31:0] word;
    word = 32'h0;
    case (op)
      OP_NOP:     word = 32'h0;
      OP_ADD:     word = r_word(rs, rt, rd, FN_ADD);
      OP_SUB:     word = r_word(rs, rt, rd, FN_SUB);
      OP_AND:     word = r_word(rs, rt, rd, FN_AND);
      OP_OR:      word = r_word(rs, rt, rd, FN_OR);
      OP_SLT:     word = r_word(rs, rt, rd, FN_SLT);
      OP_SLTU:    word = r_word(rs, rt, rd, FN_SLTU);
      OP_JR:      word = r_word(rs, 5'd0, 5'd0, FN_JR);
      OP_SYSCALL: word = r_word(5'd0, 5'd0, 5'd0, FN_SYSCALL);
      OP_MULT:    word = r_word(rs, rt, 5'd0, FN_MULT);
      OP_MULTU:   word = r_word(rs, rt, 5'd0, FN_MULTU);
      OP_DIV:     word = r_word(rs, rt, 5'd0, FN_DIV);
      OP_DIVU:    word = r_word(rs, rt, 5'd0, FN_DIVU);
      OP_MFHI:    word = r_word(5'd0, 5'd0, rd, FN_MFHI);
      OP_MFLO:    word = r_word(5'd0, 5'd0, rd, FN_MFLO);
      OP_MTHI:    word = r_word(rs, 5'd0, 5'd0, FN_MTHI);
      OP_MTLO:    word = r_word(rs, 5'd0, 5'd0, FN_MTLO);
      OP_ADDI:    word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ANDI:    word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:     word = i_word(OPC_ORI, rs, rt, imm);
      OP_LUI:     word = i_word(OPC_LUI, 5'd0, rt, imm);
      OP_LW:      word = i_word(OPC_LW, rs, rt, imm);
      OP_LH:      word = i_word(OPC_LH, rs, rt, imm);
      OP_LB:      word = i_word(OPC_LB, rs, rt, imm);
      OP_SW:      word = i_word(OPC_SW, rs, rt, imm);
      OP_SH:      word = i_word(OPC_SH, rs, rt, imm);
      OP_SB:      word = i_word(OPC_SB, rs, rt, imm);
      OP_BEQ:     word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:     word = i_word(OPC_BNE, rs, rt, imm);
      OP_JAL:     word = {OPC_JAL, target};
      OP_MFC0:    word = {OPC_COP0, COP0_MF, rt, rd, 11'd0};
      OP_MTC0:    word = {OPC_COP0, COP0_MT, rt, rd, 11'd0};
      OP_ERET:    word = ERET_WORD;
      default:    word = 32'h0;
    endcase
    return word;
  endfunction

  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_head;
  logic [31:0]      enc_word;
  logic             op_legal;
  logic             accept;
  logic             push_en;
  logic             xfer;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             unused_base_lsbs;

  // Address is always word aligned, so the low base bits are dropped on load.
  assign unused_base_lsbs = ^base_addr[1:0];

  // Ready comes only from registered occupancy; a full buffer never takes a request.
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign op_legal  = (req_op <= OP_LAST);
  assign enc_word  = encode_instr(req_op, req_rs, req_rt, req_rd, req_imm, req_target);
  assign push_en   = accept && op_legal;
  assign im_we     = !fifo_empty;
  assign xfer      = im_we && im_ready;

  assign im_wdata    = fifo_head;
  assign im_addr     = addr_q;
  assign word_cnt    = cnt_q;
  assign err_illegal = err_q;

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_en),
    .push_data (enc_word),
    .pop       (xfer),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write address: a base load wins over the post-transfer increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= RESET_ADDR;
    end else if (base_load) begin
      addr_q <= {base_addr[31:2], 2'b00};
    end else if (xfer) begin
      addr_q <= addr_q + 32'd4;
    end
  end

  // Count completed IM writes, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Remember that an undefined op was consumed; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept && !op_legal) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for the instruction encoder / IM loader: a table of every
// legal op with hand-encoded words, plus sequences for back-pressure, illegal
// ops, base loads with wrap, and asynchronous reset mid-stream.
module tb_mips_instr_encoder;
  import mips_instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        base_load;
  logic [31:0] base_addr;
  logic        im_we;
  logic        im_ready;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic [15:0] word_cnt;
  logic        err_illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_addr;
  logic [31:0] exp_cnt;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
    string       name;
  } vec_t;

  vec_t vecs[33];

  mips_instr_encoder #(
    .FIFO_DEPTH (4),
    .RESET_ADDR (32'h0000_3000),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .base_load   (base_load),
    .base_addr   (base_addr),
    .im_we       (im_we),
    .im_ready    (im_ready),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .word_cnt    (word_cnt),
    .err_illegal (err_illegal)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Log every IM transfer that the coming rising edge will perform.
  always @(negedge clk) begin
    if (reset && im_we && im_ready) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
    end
  end

  // Hard stop in case a sequence stalls beyond every local bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Present one request and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic apply_stimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] target);
    int n;
    req_op     = op;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_imm    = imm;
    req_target = target;
    req_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) report_timeout("accept");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (im_we && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (im_we) report_timeout(name);
  endtask

  task automatic check_write(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx >= wr_addr_q.size()) begin
      report_timeout(name);
    end else begin
      check_output({name, "_addr"}, wr_addr_q[idx], addr);
      check_output({name, "_data"}, wr_data_q[idx], data);
    end
  endtask

  task automatic set_vec(input int i, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] target,
                         input logic [31:0] w, input string name);
    vecs[i] = '{op, rs, rt, rd, imm, target, w, name};
  endtask

  initial begin
    // Every legal op; unused fields are deliberately non-zero so leakage shows up.
    set_vec(0,  OP_NOP,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0000_0000, "nop");
    set_vec(1,  OP_ADD,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_1820, "add");
    set_vec(2,  OP_SUB,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_1822, "sub");
    set_vec(3,  OP_AND,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_1824, "and");
    set_vec(4,  OP_OR,      5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_1825, "or");
    set_vec(5,  OP_SLT,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_182A, "slt");
    set_vec(6,  OP_SLTU,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_182B, "sltu");
    set_vec(7,  OP_JR,      5'd31, 5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h03E0_0008, "jr");
    set_vec(8,  OP_MULT,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_0018, "mult");
    set_vec(9,  OP_MULTU,   5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_0019, "multu");
    set_vec(10, OP_DIV,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_001A, "div");
    set_vec(11, OP_DIVU,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0022_001B, "divu");
    set_vec(12, OP_MFHI,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0000_1810, "mfhi");
    set_vec(13, OP_MFLO,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0000_1812, "mflo");
    set_vec(14, OP_MTHI,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0020_0011, "mthi");
    set_vec(15, OP_MTLO,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0020_0013, "mtlo");
    set_vec(16, OP_ADDI,    5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h2022_1234, "addi");
    set_vec(17, OP_ANDI,    5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h3022_1234, "andi");
    set_vec(18, OP_ORI,     5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h3422_1234, "ori");
    set_vec(19, OP_LUI,     5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h3C02_1234, "lui");
    set_vec(20, OP_LW,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h8C22_1234, "lw");
    set_vec(21, OP_LH,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h8422_1234, "lh");
    set_vec(22, OP_LB,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'h8022_1234, "lb");
    set_vec(23, OP_SW,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'hAC22_1234, "sw");
    set_vec(24, OP_SH,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'hA422_1234, "sh");
    set_vec(25, OP_SB,      5'd1,  5'd2, 5'd3,  16'h1234, 26'h3FF_FFFF, 32'hA022_1234, "sb");
    set_vec(26, OP_BEQ,     5'd1,  5'd2, 5'd3,  16'hFFFF, 26'h3FF_FFFF, 32'h1022_FFFF, "beq");
    set_vec(27, OP_BNE,     5'd1,  5'd2, 5'd3,  16'h0010, 26'h3FF_FFFF, 32'h1422_0010, "bne");
    set_vec(28, OP_JAL,     5'd1,  5'd2, 5'd3,  16'hABCD, 26'h000_0C00, 32'h0C00_0C00, "jal");
    set_vec(29, OP_MFC0,    5'd1,  5'd5, 5'd12, 16'hABCD, 26'h3FF_FFFF, 32'h4005_6000, "mfc0");
    set_vec(30, OP_MTC0,    5'd1,  5'd5, 5'd12, 16'hABCD, 26'h3FF_FFFF, 32'h4085_6000, "mtc0");
    set_vec(31, OP_ERET,    5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h4200_0018, "eret");
    set_vec(32, OP_SYSCALL, 5'd1,  5'd2, 5'd3,  16'hABCD, 26'h3FF_FFFF, 32'h0000_000C, "syscall");

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_rs     = '0;
    req_rt     = '0;
    req_rd     = '0;
    req_imm    = '0;
    req_target = '0;
    base_load  = 1'b0;
    base_addr  = '0;
    im_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_im_we",     32'(im_we),       32'd0);
    check_output("rst_im_wdata",  im_wdata,         32'h0);
    check_output("rst_im_addr",   im_addr,          32'h0000_3000);
    check_output("rst_word_cnt",  32'(word_cnt),    32'd0);
    check_output("rst_err",       32'(err_illegal), 32'd0);
    check_output("rst_req_ready", 32'(req_ready),   32'd1);

    // im_ready with nothing queued must not move the address.
    im_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("idle_ready_addr", im_addr, 32'h0000_3000);
    check_output("idle_ready_cnt",  32'(word_cnt), 32'd0);

    // Single ori streamed straight through.
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0);
    check_output("t1_im_we",   32'(im_we), 32'd1);
    check_output("t1_wdata",   im_wdata,   32'h3401_1234);
    check_output("t1_addr",    im_addr,    32'h0000_3000);
    check_output("t1_cnt_pre", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;
    check_output("t1_im_we_after", 32'(im_we),    32'd0);
    check_output("t1_cnt",         32'(word_cnt), 32'd1);
    check_output("t1_addr_after",  im_addr,       32'h0000_3004);
    exp_addr = 32'h0000_3004;
    exp_cnt  = 32'd1;

    // Table of all legal ops, written back to back.
    for (int i = 0; i < 33; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
      check_output({"t3_", vecs[i].name, "_data"}, im_wdata, vecs[i].exp_word);
      check_output({"t3_", vecs[i].name, "_addr"}, im_addr,  exp_addr);
      exp_addr = exp_addr + 32'd4;
      exp_cnt  = exp_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check_output("t3_idle", 32'(im_we),    32'd0);
    check_output("t3_cnt",  32'(word_cnt), exp_cnt);
    check_output("t3_addr", im_addr,       exp_addr);

    // Back-pressure: four words fill the buffer, the fifth waits.
    im_ready = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'(17 * (k + 1)), 26'd0);
    end
    check_output("t2_full_ready", 32'(req_ready), 32'd0);
    check_output("t2_full_we",    32'(im_we),     32'd1);
    check_output("t2_full_addr",  im_addr,        exp_addr);
    check_output("t2_full_data",  im_wdata,       32'h3401_0011);
    req_op    = OP_ORI;
    req_rs    = 5'd0;
    req_rt    = 5'd1;
    req_rd    = 5'd0;
    req_imm   = 16'h0055;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_output("t2_hold_addr",  im_addr,        exp_addr);
      check_output("t2_hold_data",  im_wdata,       32'h3401_0011);
      check_output("t2_hold_ready", 32'(req_ready), 32'd0);
    end
    im_ready = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready) report_timeout("t2_fifth_accept");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    wait_drain("t2_drain");
    check_output("t2_count", 32'(wr_addr_q.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      check_write("t2_wr", j, exp_addr + 32'(4 * j), 32'h3401_0000 + 32'(17 * (j + 1)));
    end
    exp_addr = exp_addr + 32'd20;
    exp_cnt  = exp_cnt + 32'd5;
    check_output("t2_cnt", 32'(word_cnt), exp_cnt);

    // Undefined op is swallowed and flagged; the next legal op still lands in sequence.
    apply_stimulus(6'd50, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd0);
    check_output("t4_no_write", 32'(im_we),       32'd0);
    check_output("t4_err",      32'(err_illegal), 32'd1);
    check_output("t4_addr",     im_addr,          exp_addr);
    @(posedge clk);
    #1;
    check_output("t4_err_sticky", 32'(err_illegal), 32'd1);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h0077, 26'd0);
    check_output("t4_next_data", im_wdata,          32'h3401_0077);
    check_output("t4_next_addr", im_addr,           exp_addr);
    check_output("t4_err_still", 32'(err_illegal),  32'd1);
    @(posedge clk);
    #1;
    exp_addr = exp_addr + 32'd4;
    exp_cnt  = exp_cnt + 32'd1;
    check_output("t4_cnt", 32'(word_cnt), exp_cnt);

    // Base load near the top of memory; the second word wraps to zero.
    im_ready = 1'b0;
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00A1, 26'd0);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00A2, 26'd0);
    base_load = 1'b1;
    base_addr = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    check_output("t5_base_addr", im_addr, 32'hFFFF_FFFC);
    wr_addr_q.delete();
    wr_data_q.delete();
    im_ready = 1'b1;
    wait_drain("t5_drain");
    check_output("t5_count", 32'(wr_addr_q.size()), 32'd2);
    check_write("t5_top",  0, 32'hFFFF_FFFC, 32'h3401_00A1);
    check_write("t5_wrap", 1, 32'h0000_0000, 32'h3401_00A2);
    check_output("t5_addr_after", im_addr, 32'h0000_0004);

    // Base load in the same cycle as a transfer: that word keeps the old address.
    im_ready = 1'b0;
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00C3, 26'd0);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00D4, 26'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
    im_ready  = 1'b1;
    base_load = 1'b1;
    base_addr = 32'h0000_4002;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    check_output("t5_coinc_addr", im_addr, 32'h0000_4000);
    wait_drain("t5_coinc_drain");
    check_write("t5_coinc_old", 0, 32'h0000_0004, 32'h3401_00C3);
    check_write("t5_coinc_new", 1, 32'h0000_4000, 32'h3401_00D4);
    check_output("t5_coinc_after", im_addr, 32'h0000_4004);
    exp_cnt = exp_cnt + 32'd4;
    check_output("t5_cnt", 32'(word_cnt), exp_cnt);

    // Asynchronous reset between edges with three words queued.
    im_ready = 1'b0;
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00E1, 26'd0);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00E2, 26'd0);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h00E3, 26'd0);
    check_output("t6_queued_we", 32'(im_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_im_we",    32'(im_we),       32'd0);
    check_output("t6_wdata",    im_wdata,         32'h0);
    check_output("t6_addr",     im_addr,          32'h0000_3000);
    check_output("t6_cnt",      32'(word_cnt),    32'd0);
    check_output("t6_err",      32'(err_illegal), 32'd0);
    check_output("t6_req_rdy",  32'(req_ready),   32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    im_ready = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check_output("t6_quiet_we",   32'(im_we),             32'd0);
    check_output("t6_quiet_wr",   32'(wr_addr_q.size()),  32'd0);
    check_output("t6_quiet_addr", im_addr,                32'h0000_3000);
    apply_stimulus(OP_ORI, 5'd0, 5'd1, 5'd0, 16'h0099, 26'd0);
    check_output("t6_new_data", im_wdata, 32'h3401_0099);
    check_output("t6_new_addr", im_addr,  32'h0000_3000);
    @(posedge clk);
    #1;
    check_output("t6_new_cnt", 32'(word_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
